click_gesture: RTL
==================

CLICK_GESTURE -- requirements
Module: click_gesture

Interface
REQ-001 Parameter IN_C_HZ, default 50_000_000, is the clk frequency in Hz.
REQ-002 Parameter DBL_WINDOW_MS, default 300, is the double-click window in ms.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 fast_click  input  1  one-cycle pulse per short press from the upstream click detector.
REQ-006 long_click  input  1  one-cycle pulse per long press from the upstream click detector.
REQ-007 ev_valid  output  1  gesture event available.
REQ-008 ev_ready  input  1  consumer accepts the event when high with ev_valid.
REQ-009 ev_code  output  2  event code: 01 SINGLE, 10 DOUBLE, 11 LONG, 00 only when ev_valid is low.
REQ-010 overflow  output  1  sticky flag: an event was dropped.
REQ-011 clr_ovf  input  1  synchronous clear of overflow.

Function
REQ-012 Window length CNT_TH = DBL_WINDOW_MS*(IN_C_HZ/1000) cycles; counter width $clog2(CNT_TH+1); no wrap permitted.
REQ-013 FSM states: IDLE and WAIT2; reset state is IDLE.
REQ-014 In IDLE, long_click emits LONG and the FSM stays in IDLE.
REQ-015 In IDLE, fast_click without long_click moves the FSM to WAIT2 with the window counter at 0.
REQ-016 In WAIT2, the counter increments by 1 per cycle.
REQ-017 In WAIT2, long_click emits LONG, discards the pending single, and returns the FSM to IDLE.
REQ-018 In WAIT2, fast_click without long_click emits DOUBLE and returns the FSM to IDLE.
REQ-019 In WAIT2, counter==CNT_TH-1 with no input pulse emits SINGLE and returns the FSM to IDLE.
REQ-020 Priority within one cycle is long_click > fast_click > timeout.
REQ-021 Timing: for a fast_click at cycle t, a second fast_click at t+k with 1<=k<=CNT_TH gives DOUBLE; otherwise SINGLE is emitted with ev_valid high at t+CNT_TH+1.
REQ-022 LONG and DOUBLE have ev_valid high on the cycle after the input pulse (1-cycle latency).
REQ-023 An emission loads ev_code and sets ev_valid when ev_valid==0, or when ev_valid==1 and ev_ready==1 in the same cycle (back-to-back without a bubble).
REQ-024 An emission while ev_valid==1 and ev_ready==0 is dropped, sets overflow, and leaves ev_code unchanged.
REQ-025 ev_valid==1 and ev_ready==1 with no emission clears ev_valid and sets ev_code to 00.
REQ-026 ev_code and ev_valid hold stable while ev_valid==1 and ev_ready==0.
REQ-027 When clr_ovf is asserted in the same cycle as a new drop, the set wins.

Reset
REQ-028 rst returns the FSM to IDLE mid-window, discarding any pending single.
REQ-029 rst sets counter=0, ev_valid=0, ev_code=00 and overflow=0.
REQ-030 Input pulses coincident with rst are ignored.
REQ-031 The first event after rst release can be accepted on the first cycle after release.

Structure
REQ-032 Shared package click_pkg holds typedef ev_code_t (EV_NONE=0, EV_SINGLE=1, EV_DOUBLE=2, EV_LONG=3), the FSM state enum, and a function computing CNT_TH from the clock frequency and ms value.
REQ-033 The window counter is sub-module click_window_timer with inputs start and abort, output expire (one-cycle pulse at CNT_TH-1), and an active flag.
REQ-034 All outputs are driven directly from flops; there is no combinational path from an input to an output.

Verification (IN_C_HZ=10_000, DBL_WINDOW_MS=1, so CNT_TH=10)
REQ-035 fast_click at cycle 5, ev_ready=1 -> ev_valid high at cycle 16 for one cycle, ev_code=01.
REQ-036 fast_click at cycles 5 and 15 -> DOUBLE (10) with ev_valid at cycle 16; fast_click at cycles 5 and 16 -> SINGLE at cycle 16, then the FSM is in WAIT2 again.
REQ-037 long_click at cycle 3, then fast_click at 20 with long_click at 22 -> LONG at cycle 4, LONG at 23, no SINGLE emitted.
REQ-038 ev_ready=0, long_click at cycles 3 and 8 -> ev_code=11 held, overflow=1 from cycle 9; clr_ovf at cycle 12 -> overflow=0 from cycle 13.
REQ-039 rst asserted at cycle 9 after fast_click at 5, released at 11 -> no event through cycle 30; fast+long at cycle 12 -> LONG only, FSM stays in IDLE.
REQ-040 ev_valid held with ev_ready=1 while a long_click arrives in the same cycle -> new LONG loaded with no bubble and overflow stays 0.

Source files
------------

// File: rtl/click_pkg.sv
// Shared definitions for the click gesture block: event codes, FSM states
// and the helper that converts a window length in ms into clock cycles.
package click_pkg;

    // Gesture event codes presented on ev_code
    typedef enum logic [1:0] {
        EV_NONE   = 2'b00,
        EV_SINGLE = 2'b01,
        EV_DOUBLE = 2'b10,
        EV_LONG   = 2'b11
    } ev_code_t;

    // Gesture FSM: idle, or waiting for a possible second short press
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WAIT2 = 1'b1
    } click_state_t;

    // Number of clk cycles in a window of window_ms milliseconds
    function automatic int calc_cnt_th(input int clk_hz, input int window_ms);
        return window_ms * (clk_hz / 1000);
    endfunction

endpackage

// File: rtl/click_window_timer.sv
// Double-click window timer. start clears the count and arms the timer,
// abort disarms it. expire is high for exactly the one cycle in which the
// armed count sits at CNT_TH-1; the timer then disarms itself, so the
// count never wraps.
module click_window_timer
    import click_pkg::*;
#(
    parameter int CNT_TH = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    output logic expire,
    output logic active
);

    localparam int CW = $clog2(CNT_TH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(CNT_TH - 1);

    logic [CW-1:0] cnt_r;
    logic          active_r;
    logic          expire_s;

    // Terminal-count decode of the registered count
    always_comb begin
        expire_s = 1'b0;
        if (active_r && (cnt_r == LAST_CNT)) begin
            expire_s = 1'b1;
        end else begin
            expire_s = 1'b0;
        end
    end

    // Window counter: arm on start, disarm on abort or terminal count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r    <= {CW{1'b0}};
            active_r <= 1'b0;
        end else if (start) begin
            cnt_r    <= {CW{1'b0}};
            active_r <= 1'b1;
        end else if (abort || expire_s) begin
            cnt_r    <= {CW{1'b0}};
            active_r <= 1'b0;
        end else if (active_r) begin
            cnt_r    <= cnt_r + CW'(1);
            active_r <= 1'b1;
        end else begin
            cnt_r    <= cnt_r;
            active_r <= active_r;
        end
    end

    assign expire = expire_s;
    assign active = active_r;

endmodule

// File: rtl/click_gesture.sv
// Click gesture classifier. Turns short/long press pulses into SINGLE,
// DOUBLE and LONG events on a valid/ready interface with a one-entry
// output register and a sticky overflow flag for dropped events.
module click_gesture
    import click_pkg::*;
#(
    parameter int IN_C_HZ       = 50_000_000,
    parameter int DBL_WINDOW_MS = 300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fast_click,
    input  logic       long_click,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [1:0] ev_code,
    output logic       overflow,
    input  logic       clr_ovf
);

    localparam int CNT_TH = calc_cnt_th(IN_C_HZ, DBL_WINDOW_MS);

    click_state_t state_r;
    ev_code_t     ev_code_r;
    logic         ev_valid_r;
    logic         overflow_r;

    logic         emit_s;
    ev_code_t     emit_code_s;
    logic         start_s;
    logic         abort_s;
    logic         expire_s;
    logic         timer_active_s;
    logic         load_s;
    logic         drop_s;
    logic         accept_s;

    click_window_timer #(
        .CNT_TH (CNT_TH)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (start_s),
        .abort  (abort_s),
        .expire (expire_s),
        .active (timer_active_s)
    );

    // Event decode and timer control; long press outranks short press,
    // which outranks the window timeout
    always_comb begin
        emit_s      = 1'b0;
        emit_code_s = EV_NONE;
        start_s     = 1'b0;
        abort_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (long_click) begin
                    emit_s      = 1'b1;
                    emit_code_s = EV_LONG;
                end else if (fast_click) begin
                    start_s     = 1'b1;
                end else begin
                    emit_s      = 1'b0;
                end
            end
            ST_WAIT2: begin
                if (long_click) begin
                    emit_s      = 1'b1;
                    emit_code_s = EV_LONG;
                    abort_s     = 1'b1;
                end else if (fast_click) begin
                    emit_s      = 1'b1;
                    emit_code_s = EV_DOUBLE;
                    abort_s     = 1'b1;
                end else if (expire_s && timer_active_s) begin
                    emit_s      = 1'b1;
                    emit_code_s = EV_SINGLE;
                    abort_s     = 1'b1;
                end else begin
                    emit_s      = 1'b0;
                end
            end
            default: begin
                abort_s = 1'b1;
            end
        endcase
    end

    // Output register handshake: load when the slot is free or being
    // drained this cycle, otherwise the new event is dropped
    always_comb begin
        accept_s = ev_valid_r & ev_ready;
        load_s   = emit_s & (~ev_valid_r | ev_ready);
        drop_s   = emit_s & ev_valid_r & ~ev_ready;
    end

    // Gesture FSM state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!long_click && fast_click) begin
                        state_r <= ST_WAIT2;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT2: begin
                    if (long_click || fast_click || expire_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT2;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Event output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ev_valid_r <= 1'b0;
            ev_code_r  <= EV_NONE;
        end else if (load_s) begin
            ev_valid_r <= 1'b1;
            ev_code_r  <= emit_code_s;
        end else if (accept_s) begin
            ev_valid_r <= 1'b0;
            ev_code_r  <= EV_NONE;
        end else begin
            ev_valid_r <= ev_valid_r;
            ev_code_r  <= ev_code_r;
        end
    end

    // Sticky overflow; a new drop wins over a clear in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (clr_ovf) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign ev_valid = ev_valid_r;
    assign ev_code  = ev_code_r;
    assign overflow = overflow_r;

endmodule
